// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants for the seven-segment scan driver
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/ssd_bin2bcd.sv
// rtl/ssd_bin2bcd.sv - sequential double-dabble converter, one input bit per cycle
module ssd_bin2bcd #(
  parameter int DATA_W = 9,
  parameter int BCD_D  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*BCD_D-1:0]   bcd
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  r_sh;
  logic [4*BCD_D-1:0] r_bcd;
  logic [CW-1:0]      r_cnt;
  logic [4*BCD_D-1:0] w_adj;
  logic [4*BCD_D-1:0] w_next;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_D; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_next = (4*BCD_D)'({w_adj, r_sh[DATA_W-1]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_sh  <= bin;
      r_bcd <= '0;
      r_cnt <= CW'(DATA_W);
    end else if (r_cnt != '0) begin
      r_sh  <= r_sh << 1;
      r_bcd <= w_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // bcd carries the result of the step being taken, so the final value is ready on the done edge
  assign busy = (r_cnt != '0);
  assign done = (r_cnt == CW'(1));
  assign bcd  = w_next;

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - captures ALU result and scans it onto a 7-seg display; SSD_BCD_EN selects decimal
module ssd_scan_driver import ssd_pkg::*; #(
  parameter int DATA_W      = 9,
  parameter int N_DIGITS    = 3,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              busy,
  output logic [7:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_dig [N_DIGITS];
  logic [7:0]       r_an;
  logic [6:0]       r_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // an and seg share one edge so a digit never shows on the neighbouring anode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(8'd1 << r_idx);
      r_seg <= SEG_TABLE[r_dig[r_idx]];
    end
  end

`ifdef SSD_BCD_EN
  localparam int BCD_D = (DATA_W + 2) / 3;
  localparam int EXT_D = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;

  logic [0:0]         r_state;
  logic               r_busy;
  logic               w_start;
  logic               w_cv_busy;
  logic               w_done;
  logic [4*BCD_D-1:0] w_bcd;
  logic [4*EXT_D-1:0] w_ext;

  assign w_start = (r_state == ST_IDLE) && load && !w_cv_busy;
  assign w_ext   = (4*EXT_D)'(w_bcd);

  ssd_bin2bcd #(.DATA_W(DATA_W), .BCD_D(BCD_D)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (din),
    .busy  (w_cv_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (w_start) begin
      r_state <= ST_CONV;
      r_busy  <= 1'b1;
    end else if (r_state == ST_CONV && w_done) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) r_dig[i] <= w_ext[4*i +: 4];
    end
  end

  assign busy = r_busy;
`else
  localparam int HEX_W = 4 * N_DIGITS;

  logic [HEX_W-1:0] w_hex;

  assign w_hex = HEX_W'(din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (load) begin
      for (int i = 0; i < N_DIGITS; i++) r_dig[i] <= w_hex[4*i +: 4];
    end
  end

  assign busy = 1'b0;
`endif

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - scoreboard bench for ssd_scan_driver (hex or SSD_BCD_EN build)
module tb_ssd_scan_driver;

  localparam int DATA_W   = 9;
  localparam int N_DIGITS = 3;
  localparam int RD       = 4;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic load = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic busy;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  exp_t exp_q [$];
  logic track = 1'b0;
  logic [6:0] prev_seg;

  ssd_scan_driver #(.DATA_W(DATA_W), .N_DIGITS(N_DIGITS), .REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .load  (load),
    .busy  (busy),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] digit_of(input int v, input int i);
    int p;
    p = 1;
`ifdef SSD_BCD_EN
    for (int j = 0; j < i; j++) p = p * 10;
    return 4'((v / p) % 10);
`else
    for (int j = 0; j < i; j++) p = p * 16;
    return 4'((v / p) % 16);
`endif
  endfunction

  // Monitor: anode position follows from elapsed slots; slot contents come from the queue
  always @(negedge clk) begin
    if (!rst_n) begin
      track = 1'b0;
    end else if (cyc >= 1) begin
      int idx;
      logic [7:0] want_an;
      exp_t e;
      idx = ((cyc - 1) / RD) % N_DIGITS;
      want_an = 8'hFF;
      want_an[idx] = 1'b0;
      chk("an_scan", an, want_an);
      if ((cyc - 1) % RD == 0) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("slot_an", an, e.an);
          chk("slot_seg", seg, e.seg);
          track = 1'b1;
        end else begin
          track = 1'b0;
        end
      end else if (track) begin
        chk("seg_hold", seg, prev_seg);
      end
      prev_seg = seg;
    end
  end

  task automatic drain();
    for (int t = 0; t < (2 * N_DIGITS + 2) * RD && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (RD) @(negedge clk);
  endtask

  task automatic push_slots(input int v);
    int base;
    int d;
    exp_t e;
    @(negedge clk);
    for (int t = 0; t < RD && (cyc % RD) != 0; t++) @(negedge clk);
    base = cyc / RD;
    for (int s = 0; s < 2 * N_DIGITS; s++) begin
      d = (base + s) % N_DIGITS;
      e.an = 8'hFF;
      e.an[d] = 1'b0;
      e.seg = SEG_REF[digit_of(v, d)];
      exp_q.push_back(e);
    end
    drain();
  endtask

  task automatic wait_conv(input int expect_cycles);
    int n;
    n = 0;
`ifdef SSD_BCD_EN
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, expect_cycles);
`else
    chk("busy_low", busy, 0);
    n = expect_cycles;
`endif
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    din = DATA_W'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_conv(DATA_W);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, an, 8'hFF);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dp"}, dp, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic mid_reset(input int v, input int wait_cyc);
    @(negedge clk);
    din = DATA_W'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (wait_cyc) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy_after", busy, 1'b0);
    push_slots(0);
  endtask

  initial begin
    int v;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_an", an, 8'hFE);
    chk("first_seg", seg, 7'h40);
    push_slots(0);

`ifdef SSD_BCD_EN
    do_load(511);
    push_slots(511);
    // a second load during conversion must be dropped
    @(negedge clk);
    din = 9'd100;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    din = 9'd7;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_conv(DATA_W - 2);
    push_slots(100);
    mid_reset(255, 3);
`else
    do_load(9'h1A5);
    push_slots(9'h1A5);
    // back-to-back loads: the later value wins
    @(negedge clk);
    din = 9'h0FF;
    load = 1'b1;
    @(negedge clk);
    din = 9'h123;
    @(negedge clk);
    load = 1'b0;
    push_slots(9'h123);
    mid_reset(9'h155, 2);
`endif

    do_load(0);
    push_slots(0);
    for (int k = 0; k < 8; k++) begin
      v = int'($urandom_range(0, 511));
      do_load(v);
      push_slots(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
